// File: rtl/pll_phase_ctrl.sv
// pll_phase_ctrl: supervisor and dynamic phase-shift sequencer for the
// fractional system-clock PLL. It resets the PLL after power-up and after
// lock loss, filters the locked indication, and walks one output counter's
// phase, one step at a time, to a signed offset from the compiled phase.
// Runs entirely in the reference-clock domain.
module pll_phase_ctrl #(
   parameter int         PHASE_W    = 8,
   parameter logic [4:0] CNTSEL     = 5'd1,
   parameter int         EN_CYCLES  = 2,
   parameter int         RST_CYCLES = 16,
   parameter int         LOCK_FILT  = 8,
   parameter int         TIMEOUT    = 1023
) (
   input  logic                      refclk_i,
   input  logic                      rst_i,
   input  logic                      req_i,
   input  logic signed [PHASE_W-1:0] target_phase_i,
   input  logic                      pll_locked_i,
   input  logic                      phase_done_i,
   output logic                      pll_rst_o,
   output logic                      phase_en_o,
   output logic                      updn_o,
   output logic [4:0]                cntsel_o,
   output logic signed [PHASE_W-1:0] cur_phase_o,
   output logic                      busy_o,
   output logic                      ready_o,
   output logic                      err_o
);

   // One shared down-counter width covers reset pulse, enable pulse and timeout.
   localparam int CNT_MAX_A = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
   localparam int CNT_MAX   = (CNT_MAX_A > EN_CYCLES) ? CNT_MAX_A : EN_CYCLES;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);
   localparam int LF_W      = $clog2(LOCK_FILT + 1);

   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] EN_LAST  = CNT_W'(EN_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [LF_W-1:0]  LF_LAST  = LF_W'(LOCK_FILT - 1);
   localparam logic [LF_W-1:0]  LF_ONE   = LF_W'(1);
   localparam logic signed [PHASE_W-1:0] PH_ONE  = PHASE_W'(1);
   localparam logic signed [PHASE_W-1:0] PH_ZERO = '0;

   typedef enum logic [2:0] {
      S_RST_PLL,
      S_WAIT_LOCK,
      S_IDLE,
      S_STEP_EN,
      S_WAIT_LO,
      S_WAIT_HI
   } state_t;

   state_t                      state_q;
   logic [CNT_W-1:0]            cnt_q;
   logic [LF_W-1:0]             lk_cnt_q;
   logic                        locked_s1_q, locked_s2_q;
   logic                        done_s1_q, done_s2_q;
   logic signed [PHASE_W-1:0]   tgt_q, cur_q;
   logic                        pll_rst_q, phase_en_q, updn_q, err_q;

   logic                        running_d, lock_lost_d, lock_ok_d;
   logic                        step_up_d, timeout_d;
   logic signed [PHASE_W-1:0]   cur_step_d;
   logic [LF_W-1:0]             lk_cnt_d;

   // Two-flop synchronisers for the asynchronous PLL status inputs.
   always_ff @(posedge refclk_i or posedge rst_i) begin
      if (rst_i) begin
         locked_s1_q <= 1'b0;
         locked_s2_q <= 1'b0;
         done_s1_q   <= 1'b0;
         done_s2_q   <= 1'b0;
      end else begin
         locked_s1_q <= pll_locked_i;
         locked_s2_q <= locked_s1_q;
         done_s1_q   <= phase_done_i;
         done_s2_q   <= done_s1_q;
      end
   end

   // Decode lock-filter hits, timeout, step direction and the next stepped phase.
   always_comb begin
      running_d   = (state_q == S_IDLE) || (state_q == S_STEP_EN) ||
                    (state_q == S_WAIT_LO) || (state_q == S_WAIT_HI);
      lock_lost_d = running_d && !locked_s2_q && (lk_cnt_q == LF_LAST);
      lock_ok_d   = (state_q == S_WAIT_LOCK) && locked_s2_q && (lk_cnt_q == LF_LAST);
      timeout_d   = (cnt_q == TO_LAST);
      step_up_d   = (tgt_q > cur_q);
      cur_step_d  = updn_q ? (cur_q + PH_ONE) : (cur_q - PH_ONE);
      lk_cnt_d    = '0;
      if (state_q == S_WAIT_LOCK) begin
         if (locked_s2_q && !lock_ok_d) lk_cnt_d = lk_cnt_q + LF_ONE;
      end else if (running_d) begin
         if (!locked_s2_q && !lock_lost_d) lk_cnt_d = lk_cnt_q + LF_ONE;
      end
   end

   // Lock filter: counts consecutive locked cycles while acquiring, unlocked cycles while running.
   always_ff @(posedge refclk_i or posedge rst_i) begin
      if (rst_i) lk_cnt_q <= '0;
      else       lk_cnt_q <= lk_cnt_d;
   end

   // Main sequencer: PLL reset, lock wait, and the phase-step handshake.
   always_ff @(posedge refclk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= S_RST_PLL;
         cnt_q      <= '0;
         pll_rst_q  <= 1'b1;
         phase_en_q <= 1'b0;
         updn_q     <= 1'b0;
         cur_q      <= PH_ZERO;
         tgt_q      <= PH_ZERO;
         err_q      <= 1'b0;
      end else begin
         if (req_i) begin
            tgt_q <= target_phase_i;
            err_q <= 1'b0;
         end
         if (lock_lost_d) begin
            // PLL drops back to its compiled phase; tgt is kept for re-application.
            state_q    <= S_RST_PLL;
            cnt_q      <= '0;
            pll_rst_q  <= 1'b1;
            phase_en_q <= 1'b0;
            cur_q      <= PH_ZERO;
         end else begin
            unique case (state_q)
               S_RST_PLL: begin
                  if (cnt_q == RST_LAST) begin
                     state_q   <= S_WAIT_LOCK;
                     pll_rst_q <= 1'b0;
                     cnt_q     <= '0;
                  end else begin
                     cnt_q <= cnt_q + CNT_ONE;
                  end
               end
               S_WAIT_LOCK: begin
                  if (lock_ok_d) state_q <= S_IDLE;
               end
               S_IDLE: begin
                  if (tgt_q != cur_q) begin
                     state_q    <= S_STEP_EN;
                     phase_en_q <= 1'b1;
                     updn_q     <= step_up_d;
                     cnt_q      <= '0;
                  end
               end
               S_STEP_EN: begin
                  if (cnt_q == EN_LAST) begin
                     state_q    <= S_WAIT_LO;
                     phase_en_q <= 1'b0;
                     cnt_q      <= '0;
                  end else begin
                     cnt_q <= cnt_q + CNT_ONE;
                  end
               end
               S_WAIT_LO, S_WAIT_HI: begin
                  if ((state_q == S_WAIT_LO) && !done_s2_q) begin
                     state_q <= S_WAIT_HI;
                     cnt_q   <= '0;
                  end else if ((state_q == S_WAIT_HI) && done_s2_q) begin
                     state_q <= S_IDLE;
                     cur_q   <= cur_step_d;
                     cnt_q   <= '0;
                  end else if (timeout_d) begin
                     state_q   <= S_RST_PLL;
                     cnt_q     <= '0;
                     pll_rst_q <= 1'b1;
                     cur_q     <= PH_ZERO;
                     err_q     <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + CNT_ONE;
                  end
               end
               default: begin
                  state_q   <= S_RST_PLL;
                  cnt_q     <= '0;
                  pll_rst_q <= 1'b1;
               end
            endcase
         end
      end
   end

   assign pll_rst_o   = pll_rst_q;
   assign phase_en_o  = phase_en_q;
   assign updn_o      = updn_q;
   assign cntsel_o    = CNTSEL;
   assign cur_phase_o = cur_q;
   assign err_o       = err_q;
   assign ready_o     = (state_q == S_IDLE) && (tgt_q == cur_q);
   assign busy_o      = !ready_o;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Testbench for pll_phase_ctrl: directed vector table for target stepping plus
// hand-written sequences for reset release, retarget, timeout, lock loss,
// lock glitch and asynchronous mid-operation reset.
`timescale 1ns/1ps
module tb_pll_phase_ctrl;

   logic              refclk = 1'b0;
   logic              rst = 1'b1;
   logic              req = 1'b0;
   logic signed [7:0] target_phase = '0;
   logic              pll_locked;
   logic              phase_done = 1'b1;
   logic              pll_rst, phase_en, updn, busy, ready, err;
   logic [4:0]        cntsel;
   logic signed [7:0] cur_phase;

   logic lock_want = 1'b0;
   logic hold_high = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   always #10 refclk = ~refclk;

   // PLL stays unlocked while its reset is asserted.
   assign pll_locked = lock_want & ~pll_rst;

   pll_phase_ctrl #(
      .PHASE_W(8), .CNTSEL(5'd1), .EN_CYCLES(2), .RST_CYCLES(16),
      .LOCK_FILT(8), .TIMEOUT(1023)
   ) dut (
      .refclk_i(refclk), .rst_i(rst), .req_i(req), .target_phase_i(target_phase),
      .pll_locked_i(pll_locked), .phase_done_i(phase_done),
      .pll_rst_o(pll_rst), .phase_en_o(phase_en), .updn_o(updn), .cntsel_o(cntsel),
      .cur_phase_o(cur_phase), .busy_o(busy), .ready_o(ready), .err_o(err)
   );

   // PLL phase-step model: 4 cycles after phase_en rises, phase_done goes low for 5 cycles.
   int   pd_dly = 0;
   logic en_prev_m = 1'b0;
   always begin
      @(posedge refclk); #1;
      if (rst) begin
         pd_dly = 0;
         phase_done = 1'b1;
      end else if (phase_en && !en_prev_m && !hold_high) begin
         pd_dly = 1;
      end else if (pd_dly != 0) begin
         pd_dly++;
         if (pd_dly == 5) phase_done = 1'b0;
         if (pd_dly == 10) begin
            phase_done = 1'b1;
            pd_dly = 0;
         end
      end
      en_prev_m = phase_en;
   end

   // phase_en pulse monitor: widths, direction, updn stability.
   int   up_cnt = 0, dn_cnt = 0, bad_w = 0, upd_chg = 0, pw = 0;
   logic en_prev = 1'b0, upd_start = 1'b0;
   always begin
      @(posedge refclk); #1;
      if (rst) begin
         en_prev = 1'b0;
      end else begin
         if (phase_en && !en_prev) begin
            pw = 1;
            upd_start = updn;
         end else if (phase_en) begin
            pw++;
            if (updn != upd_start) upd_chg++;
         end else if (en_prev) begin
            if (pw != 2) bad_w++;
            if (upd_start) up_cnt++;
            else dn_cnt++;
         end
         en_prev = phase_en;
      end
   end

   // pll_rst pulse monitor.
   int rst_pulses = 0, rst_w = 0, rcnt = 0;
   always begin
      @(posedge refclk); #1;
      if (rst) rcnt = 0;
      else if (pll_rst) rcnt++;
      else if (rcnt != 0) begin
         rst_w = rcnt;
         rst_pulses++;
         rcnt = 0;
      end
   end

   // cur_phase monitor: every change must be a single +1/-1 step.
   logic signed [7:0] cur_prev = '0;
   logic signed [7:0] dif;
   int cur_chg = 0, cur_jump = 0;
   always begin
      @(posedge refclk); #1;
      if (rst) cur_prev = '0;
      else if (cur_phase != cur_prev) begin
         dif = cur_phase - cur_prev;
         cur_chg++;
         if (dif != 8'sd1 && dif != -8'sd1) cur_jump++;
         cur_prev = cur_phase;
      end
   end

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_rng(input string name, input longint act, input longint lo, input longint hi);
      n_tests++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge refclk);
      #2;
   endtask

   task automatic do_req(input logic signed [7:0] t);
      target_phase = t;
      req = 1'b1;
      cyc(1);
      req = 1'b0;
   endtask

   task automatic wait_ready(input int maxc);
      int k;
      k = 0;
      while (!ready && k < maxc) begin
         cyc(1);
         k++;
      end
   endtask

   typedef struct {
      logic signed [7:0] tgt;
      int                ups;
      int                dns;
   } vec_t;

   vec_t vt [6];

   initial begin
      int n, up0, dn0, bw0, uc0, cc0, cj0, rp0;
      logic seen, pe_at;
      logic signed [7:0] cur_at;

      vt[0] = '{tgt: 8'sd3,   ups: 3,   dns: 0};
      vt[1] = '{tgt: -8'sd2,  ups: 0,   dns: 5};
      vt[2] = '{tgt: 8'sd127, ups: 129, dns: 0};
      vt[3] = '{tgt: 8'h80,   ups: 0,   dns: 255};
      vt[4] = '{tgt: 8'sd0,   ups: 128, dns: 0};
      vt[5] = '{tgt: 8'sd0,   ups: 0,   dns: 0};

      // Reset values while rst is held.
      cyc(3);
      check("rst_pll_rst", pll_rst, 1);
      check("rst_phase_en", phase_en, 0);
      check("rst_updn", updn, 0);
      check("rst_cntsel", cntsel, 1);
      check("rst_cur", cur_phase, 0);
      check("rst_busy", busy, 1);
      check("rst_ready", ready, 0);
      check("rst_err", err, 0);

      // Reset release: pll_rst width, then lock at cycle 30 and ready near cycle 40.
      rst = 1'b0;
      n = 0;
      while (pll_rst && n < 40) begin
         cyc(1);
         n++;
      end
      check("pwrup_rst_width", n, 16);
      cyc(30 - n);
      lock_want = 1'b1;
      n = 30;
      while (!ready && n < 80) begin
         cyc(1);
         n++;
      end
      check_rng("pwrup_ready_cycle", n, 39, 41);
      check("pwrup_cur", cur_phase, 0);
      check("pwrup_busy", busy, 0);

      // Table-driven targets.
      for (int i = 0; i < 6; i++) begin
         up0 = up_cnt; dn0 = dn_cnt; bw0 = bad_w; uc0 = upd_chg; cc0 = cur_chg; cj0 = cur_jump;
         do_req(vt[i].tgt);
         wait_ready((vt[i].ups + vt[i].dns) * 30 + 50);
         check($sformatf("vec%0d_ready", i), ready, 1);
         check($sformatf("vec%0d_cur", i), cur_phase, vt[i].tgt);
         check($sformatf("vec%0d_ups", i), up_cnt - up0, vt[i].ups);
         check($sformatf("vec%0d_dns", i), dn_cnt - dn0, vt[i].dns);
         check($sformatf("vec%0d_width", i), bad_w - bw0, 0);
         check($sformatf("vec%0d_updn_stable", i), upd_chg - uc0, 0);
         check($sformatf("vec%0d_steps", i), cur_chg - cc0, vt[i].ups + vt[i].dns);
         check($sformatf("vec%0d_jumps", i), cur_jump - cj0, 0);
         check($sformatf("vec%0d_err", i), err, 0);
         check($sformatf("vec%0d_cntsel", i), cntsel, 1);
      end

      // Retarget to 0 while the first step toward +4 is waiting for phase_done high.
      up0 = up_cnt; dn0 = dn_cnt;
      do_req(8'sd4);
      n = 0;
      while (phase_done && n < 50) begin
         cyc(1);
         n++;
      end
      cyc(3);
      do_req(8'sd0);
      n = 0;
      while (cur_phase == 0 && n < 50) begin
         cyc(1);
         n++;
      end
      check("retgt_first_step", cur_phase, 1);
      wait_ready(200);
      check("retgt_ready", ready, 1);
      check("retgt_cur", cur_phase, 0);
      check("retgt_ups", up_cnt - up0, 1);
      check("retgt_dns", dn_cnt - dn0, 1);

      // Timeout: phase_done never goes low.
      do_req(8'sd1);
      wait_ready(100);
      check("to_pre_cur", cur_phase, 1);
      hold_high = 1'b1;
      rp0 = rst_pulses;
      do_req(8'sd3);
      n = 0;
      while (!phase_en && n < 20) begin
         cyc(1);
         n++;
      end
      n = 0;
      while (phase_en && n < 20) begin
         cyc(1);
         n++;
      end
      n = 0;
      while (!err && n < 1100) begin
         cyc(1);
         n++;
      end
      check("to_cycles", n, 1023);
      check("to_err", err, 1);
      check("to_pll_rst", pll_rst, 1);
      check("to_cur", cur_phase, 0);
      check("to_ready", ready, 0);
      hold_high = 1'b0;
      cyc(20);
      check("to_rst_pulses", rst_pulses - rp0, 1);
      check("to_rst_width", rst_w, 16);
      wait_ready(300);
      check("to_resume_cur", cur_phase, 3);
      check("to_err_sticky", err, 1);
      do_req(8'sd3);
      check("to_req_clears_err", err, 0);
      check("to_req_ready", ready, 1);

      // Lock loss during step 2 of target +5.
      do_req(8'sd0);
      wait_ready(200);
      do_req(8'sd5);
      n = 0;
      while (cur_phase != 1 && n < 60) begin
         cyc(1);
         n++;
      end
      n = 0;
      while (!phase_en && n < 40) begin
         cyc(1);
         n++;
      end
      check("ll_step2_started", phase_en, 1);
      rp0 = rst_pulses;
      lock_want = 1'b0;
      seen = 1'b0;
      pe_at = 1'b1;
      cur_at = 8'sd127;
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         if (pll_rst && !seen) begin
            seen = 1'b1;
            pe_at = phase_en;
            cur_at = cur_phase;
         end
      end
      lock_want = 1'b1;
      check("ll_rst_seen", seen, 1);
      check("ll_phase_en_low", pe_at, 0);
      check("ll_cur_zero", cur_at, 0);
      up0 = up_cnt;
      wait_ready(400);
      check("ll_ready", ready, 1);
      check("ll_cur", cur_phase, 5);
      check("ll_reapply_ups", up_cnt - up0, 5);
      check("ll_rst_pulses", rst_pulses - rp0, 1);
      check("ll_rst_width", rst_w, 16);

      // Short lock glitch must be filtered out.
      rp0 = rst_pulses;
      lock_want = 1'b0;
      cyc(5);
      lock_want = 1'b1;
      cyc(30);
      check("gl_no_rst", rst_pulses - rp0, 0);
      check("gl_pll_rst", pll_rst, 0);
      check("gl_ready", ready, 1);
      check("gl_cur", cur_phase, 5);

      // Asynchronous reset in the middle of stepping.
      do_req(-8'sd3);
      n = 0;
      while (cur_phase != 3 && n < 100) begin
         cyc(1);
         n++;
      end
      check("mr_mid_cur", cur_phase, 3);
      #5;
      rst = 1'b1;
      #1;
      check("mr_pll_rst", pll_rst, 1);
      check("mr_phase_en", phase_en, 0);
      check("mr_cur", cur_phase, 0);
      check("mr_busy", busy, 1);
      check("mr_ready", ready, 0);
      check("mr_updn", updn, 0);
      check("mr_err", err, 0);
      cyc(2);
      rst = 1'b0;
      cyc(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog so the bench always terminates.
   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached, tests so far %0d", n_tests);
      $fatal(1, "watchdog");
   end

endmodule
